// File: rtl/mp_add_pkg.sv
// Shared types and constants for the multi-precision add/subtract sequencer.
package mp_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int BYTE_W = 8;

    // Width of the byte index; never narrower than one bit so NUM_BYTES = 1 still works.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/byte_adder8.sv
// Combinational 8-bit ripple-carry adder built from per-bit full adders.
module byte_adder8
    import mp_add_pkg::*;
(
    input  logic [BYTE_W-1:0] a,
    input  logic [BYTE_W-1:0] b,
    input  logic              ci,
    output logic [BYTE_W-1:0] s,
    output logic              co
);

    logic [BYTE_W:0] c;

    assign c[0] = ci;

    for (genvar gi = 0; gi < BYTE_W; gi++) begin : g_fa
        assign s[gi]   = a[gi] ^ b[gi] ^ c[gi];
        assign c[gi+1] = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
    end

    assign co = c[BYTE_W];

endmodule

// File: rtl/mp_add_seq.sv
// Byte-serial multi-precision add/subtract sequencer (LSB byte first).
// Optional zero flag port is enabled with ADD_SEQ_ZERO_FLAG_EN.
module mp_add_seq
    import mp_add_pkg::*;
#(
    parameter int NUM_BYTES = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [BYTE_W*NUM_BYTES-1:0] op_a,
    input  logic [BYTE_W*NUM_BYTES-1:0] op_b,
    input  logic                        op_sub,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [BYTE_W*NUM_BYTES-1:0] result,
    output logic                        carry_out,
`ifdef ADD_SEQ_ZERO_FLAG_EN
    output logic                        zero,
`endif
    output logic                        overflow
);

    localparam int W     = BYTE_W * NUM_BYTES;
    localparam int IDX_W = idx_width(NUM_BYTES);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [W-1:0]       a_q, a_d;
    logic [W-1:0]       b_q, b_d;
    logic [W-1:0]       result_q, result_d;
    logic               carry_q, carry_d;
    logic               carry_out_q, carry_out_d;
    logic               overflow_q, overflow_d;
    logic               zero_q, zero_d;

    logic [IDX_W+2:0]   bit_off;
    logic [BYTE_W-1:0]  sum;
    logic               cout;
    logic               last_byte;

    assign bit_off   = {idx_q, 3'b000};
    assign last_byte = (idx_q == IDX_W'(NUM_BYTES - 1));

    byte_adder8 u_byte_adder8 (
        .a  (a_q[bit_off +: BYTE_W]),
        .b  (b_q[bit_off +: BYTE_W]),
        .ci (carry_q),
        .s  (sum),
        .co (cout)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        a_d         = a_q;
        b_d         = b_q;
        result_d    = result_q;
        carry_d     = carry_q;
        carry_out_d = carry_out_q;
        overflow_d  = overflow_q;
        zero_d      = zero_q;
        in_ready    = 1'b0;
        out_valid   = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    // Subtraction is A + ~B + 1: the +1 enters through the carry register.
                    a_d     = op_a;
                    b_d     = op_sub ? ~op_b : op_b;
                    carry_d = op_sub;
                    idx_d   = '0;
                    zero_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                result_d[bit_off +: BYTE_W] = sum;
                carry_d = cout;
                zero_d  = zero_q & (sum == '0);
                if (last_byte) begin
                    carry_out_d = cout;
                    overflow_d  = (a_q[W-1] == b_q[W-1]) && (sum[BYTE_W-1] != a_q[W-1]);
                    state_d     = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            result_q    <= '0;
            carry_q     <= 1'b0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            a_q         <= a_d;
            b_q         <= b_d;
            result_q    <= result_d;
            carry_q     <= carry_d;
            carry_out_q <= carry_out_d;
            overflow_q  <= overflow_d;
            zero_q      <= zero_d;
        end
    end

    assign result    = result_q;
    assign carry_out = carry_out_q;
    assign overflow  = overflow_q;
`ifdef ADD_SEQ_ZERO_FLAG_EN
    assign zero      = zero_q;
`else
    logic unused_zero;
    assign unused_zero = zero_q;
`endif

endmodule

// File: tb/tb_mp_add_seq.sv
// Self-checking bench for mp_add_seq (NUM_BYTES = 4): directed cases plus randomized ops.
module tb_mp_add_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        op_sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        carry_out;
    logic        overflow;
`ifdef ADD_SEQ_ZERO_FLAG_EN
    logic        zero;
`endif

    int checks = 0;
    int errors = 0;

    mp_add_seq #(.NUM_BYTES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_sub    (op_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry_out (carry_out),
`ifdef ADD_SEQ_ZERO_FLAG_EN
        .zero      (zero),
`endif
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the full-width operands.
    task automatic model(input logic [31:0] a, input logic [31:0] b, input logic sub,
                         output logic [31:0] r, output logic c, output logic v);
        logic [32:0] t;
        if (!sub) begin
            t = {1'b0, a} + {1'b0, b};
            r = t[31:0];
            c = t[32];
            v = (a[31] == b[31]) && (r[31] != a[31]);
        end else begin
            r = a - b;
            c = (a >= b);
            v = (a[31] != b[31]) && (r[31] != a[31]);
        end
    endtask

    // Present operands, wait for acceptance, then count clocks until out_valid.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sub,
                         input string tag);
        int  lat;
        bit  acc;
        @(negedge clk);
        op_a = a; op_b = b; op_sub = sub; in_valid = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (in_ready) begin
                acc = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check({tag, "_accept"}, 32'(acc), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({tag, "_busy"}, 32'(in_ready), 32'd0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'd4);
    endtask

    task automatic check_result(input string tag, input logic [31:0] er,
                                input logic ec, input logic ev);
        check({tag, "_result"}, result, er);
        check({tag, "_carry"}, 32'(carry_out), 32'(ec));
        check({tag, "_ovf"}, 32'(overflow), 32'(ev));
`ifdef ADD_SEQ_ZERO_FLAG_EN
        check({tag, "_zero"}, 32'(zero), 32'(er == 32'd0));
`endif
        $display("op %s a=%h b=%h sub=%0d result=%h carry=%0d ovf=%0d",
                 tag, op_a, op_b, op_sub, result, carry_out, overflow);
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_drained"}, 32'(out_valid), 32'd0);
        check({tag, "_ready_again"}, 32'(in_ready), 32'd1);
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sub,
                          input logic [31:0] er, input logic ec, input logic ev,
                          input string tag);
        issue(a, b, sub, tag);
        check_result(tag, er, ec, ev);
        handshake(tag);
    endtask

    initial begin
        logic [31:0] ra, rb, mr;
        logic        rs, mc, mv;

        rst_n = 1'b0; in_valid = 1'b0; op_a = '0; op_b = '0; op_sub = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_carry", 32'(carry_out), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);

        run_op(32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0, "add_ff_1");
        run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, "add_wrap");
        run_op(32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, "sub_borrow");
        run_op(32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, "sub_ovf");
        run_op(32'h12345678, 32'h12345678, 1'b1, 32'h00000000, 1'b1, 1'b0, "sub_equal");

        // Backpressure: result held while out_ready low and new operands wait.
        issue(32'h7FFFFFFF, 32'h00000001, 1'b0, "add_ovf");
        check_result("add_ovf", 32'h80000000, 1'b0, 1'b1);
        op_a = 32'h00000011; op_b = 32'h00000022; op_sub = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_result", result, 32'h80000000);
            check("bp_ovf", 32'(overflow), 32'd1);
            check("bp_carry", 32'(carry_out), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_release_valid", 32'(out_valid), 32'd0);
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_next_accepted", 32'(in_ready), 32'd0);
        begin
            int lat;
            lat = 0;
            while (!out_valid && lat < 20) begin
                @(posedge clk); #1;
                lat++;
            end
            check("bp_next_latency", 32'(lat), 32'd4);
        end
        check_result("bp_next", 32'h00000033, 1'b0, 1'b0);
        handshake("bp_next");

        // Asynchronous reset in the middle of RUN (byte index 2).
        @(negedge clk);
        op_a = 32'hAAAAAAAA; op_b = 32'h55555555; op_sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_result", result, 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0, 1'b0, "post_rst");

        for (int n = 0; n < 16; n++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom_range(0, 1));
            if (n % 4 == 0) rb = ra;
            model(ra, rb, rs, mr, mc, mv);
            run_op(ra, rb, rs, mr, mc, mv, $sformatf("rnd%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
